// File: rtl/weight_pkg.sv
// weight_pkg: shared lane types, FSM states and build defaults
// for the serial-to-parallel weight loader.
`ifndef DIM_C
`define DIM_C 4
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif

package weight_pkg;

  localparam int DIM_C_DEF        = `DIM_C;
  localparam int WEIGHT_WIDTH_DEF = `WEIGHT_WIDTH;
  localparam int LANE_CNT_W       = $clog2(DIM_C_DEF + 1);

  typedef logic [WEIGHT_WIDTH_DEF-1:0] weight_t;
  typedef weight_t [DIM_C_DEF-1:0]     weight_vec_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wload_state_e;

endpackage

// File: rtl/weight_out_buf.sv
// weight_out_buf: single-entry output holding register with
// valid/ready and the short-vector flag.
module weight_out_buf
  import weight_pkg::*;
#(
  parameter int DIM_C        = DIM_C_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load,
  input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] load_vec,
  input  logic                               load_part,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] out,
  output logic                               out_partial
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out         <= '0;
      out_partial <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out         <= load_vec;
      out_partial <= load_part;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: assembles DIM_C serial weights into a lane vector.
// Define WLOAD_VEC_CNT_EN to add the retired-vector counter vec_cnt.
`ifndef DIM_C
`define DIM_C 4
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif

module weight_loader
  import weight_pkg::*;
#(
  parameter int DIM_C        = `DIM_C,
  parameter int WEIGHT_WIDTH = `WEIGHT_WIDTH,
  parameter int CNT_W        = $clog2(DIM_C + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WEIGHT_WIDTH-1:0]            in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] out,
  output logic                               out_partial
`ifdef WLOAD_VEC_CNT_EN
  ,
  output logic [15:0]                        vec_cnt
`endif
);

  typedef logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] vec_t;

  wload_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  vec_t             asm_q, asm_d;
  logic             part_q, part_d;

  vec_t vec_new;
  vec_t load_vec;
  logic load;
  logic load_part;
  logic accept;
  logic last_lane;
  logic close;
  logic flag;
  logic out_free;

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid & in_ready;
  assign last_lane = (cnt_q == CNT_W'(DIM_C - 1));
  assign close     = accept & (last_lane | in_last);
  assign flag      = in_last & ~last_lane;
  assign out_free  = ~out_valid | out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    part_d    = part_q;
    load      = 1'b0;
    load_vec  = asm_q;
    load_part = part_q;
    vec_new   = asm_q;
    // Upper lanes are already zero since asm clears on every close
    for (int i = 0; i < DIM_C; i++) begin
      if (cnt_q == CNT_W'(i)) vec_new[i] = in_data;
    end
    case (state_q)
      FILL: begin
        if (close) begin
          cnt_d = '0;
          if (out_free) begin
            load      = 1'b1;
            load_vec  = vec_new;
            load_part = flag;
            asm_d     = '0;
          end else begin
            state_d = FULL;
            asm_d   = vec_new;
            part_d  = flag;
          end
        end else if (accept) begin
          asm_d = vec_new;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FULL: begin
        if (out_free) begin
          load    = 1'b1;
          asm_d   = '0;
          part_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      asm_q   <= '0;
      part_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      part_q  <= part_d;
    end
  end

  weight_out_buf #(
    .DIM_C        (DIM_C),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_vec    (load_vec),
    .load_part   (load_part),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out         (out),
    .out_partial (out_partial)
  );

`ifdef WLOAD_VEC_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= '0;
    end else if (out_valid && out_ready) begin
      vec_cnt <= vec_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: scoreboard bench for weight_loader, DIM_C=4,
// WEIGHT_WIDTH=8; vec_cnt checks when WLOAD_VEC_CNT_EN is defined.
module tb_weight_loader;

  localparam int DC = 4;
  localparam int WW = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [WW-1:0]          in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DC-1:0][WW-1:0]  out_vec;
  logic                   out_partial;
`ifdef WLOAD_VEC_CNT_EN
  logic [15:0]            vec_cnt;
`endif

  always #5 clk = ~clk;

  weight_loader #(
    .DIM_C        (DC),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out_vec),
    .out_partial (out_partial)
`ifdef WLOAD_VEC_CNT_EN
    ,
    .vec_cnt     (vec_cnt)
`endif
  );

  typedef struct packed {
    logic [DC-1:0][WW-1:0] vec;
    logic                  part;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   preload_req = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, sampled 1 time unit before each rising edge
  int                    m_cnt;
  logic [DC-1:0][WW-1:0] m_asm;
  logic                  m_full;
  logic                  m_vld;
  logic [15:0]           m_vc;
  int                    preload_ack = 0;

  always @(negedge clk) begin
    logic retire;
    logic loaded;
    exp_t e;
    #4;
    if (!rst_n) begin
      m_cnt  = 0;
      m_asm  = '0;
      m_full = 1'b0;
      m_vld  = 1'b0;
      m_vc   = '0;
      q.delete();
    end else begin
      if (preload_ack != preload_req) begin
        preload_ack = preload_req;
        m_vc = 16'hFFFF;
      end
      chk("in_ready", in_ready, !m_full);
      chk("out_valid", out_valid, m_vld);
`ifdef WLOAD_VEC_CNT_EN
      chk("vec_cnt", vec_cnt, m_vc);
`endif
      if (out_valid && q.size() > 0) begin
        chk("out", out_vec, q[0].vec);
        chk("out_partial", out_partial, q[0].part);
      end
      retire = m_vld && out_ready;
      loaded = 1'b0;
      if (retire) begin
        m_vc = m_vc + 16'd1;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (m_full) begin
        if (out_ready) begin
          m_full = 1'b0;
          loaded = 1'b1;
        end
      end else if (in_valid) begin
        m_asm[m_cnt] = in_data;
        if (m_cnt == DC - 1 || in_last) begin
          e.vec  = m_asm;
          e.part = in_last && (m_cnt != DC - 1);
          q.push_back(e);
          m_asm = '0;
          m_cnt = 0;
          if (!m_vld || out_ready) loaded = 1'b1;
          else m_full = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      if (loaded) m_vld = 1'b1;
      else if (retire) m_vld = 1'b0;
    end
  end

  task automatic send(input logic [WW-1:0] d, input logic l);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #4;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #4;
      t++;
    end
    if (t >= 50) chk("send_timeout", in_ready, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("rst_out", out_vec, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_partial", out_partial, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle();
    #1;
    chk("full_vec", out_vec, 32'h44332211);
    chk("full_valid", out_valid, 1);
    chk("full_partial", out_partial, 0);

    send(8'hA1, 0); send(8'hA2, 1);
    idle();
    #1;
    chk("short_vec", out_vec, 32'h0000A2A1);
    chk("short_partial", out_partial, 1);

    in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_last = 1'b0;
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 1);
    idle();
    #1;
    chk("after_short_vec", out_vec, 32'hB4B3B2B1);
    chk("last_on_lane3", out_partial, 0);

    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'hC0 + 8'(i), 0);
    idle();
    #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_first", out_vec, 32'hC4C3C2C1);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_hold", out_vec, 32'hC4C3C2C1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_second", out_vec, 32'hC8C7C6C5);
    chk("bp_in_ready_back", in_ready, 1);

    for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), 0);
    idle();
    repeat (3) @(negedge clk);

    send(8'hE1, 0); send(8'hE2, 0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", out_vec, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    #4;
    rst_n = 1'b1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    idle();
    #1;
    chk("post_rst_vec", out_vec, 32'h04030201);

`ifdef WLOAD_VEC_CNT_EN
    for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), 0);
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("vec_cnt_3", vec_cnt, 3);
    @(negedge clk);
    force dut.vec_cnt = 16'hFFFF;
    preload_req = preload_req + 1;
    #1;
    release dut.vec_cnt;
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 0);
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("vec_cnt_wrap", vec_cnt, 0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Serial-to-parallel weight writer. Accepts one weight per beat on a valid/ready stream and assembles DIM_C weights into a lane vector.
- Presents the completed vector on a valid/ready output. That output drives the parallel `[DIM_C-1:0][WEIGHT_WIDTH-1:0]` input of the per-cycle weight register in front of the tlutMul array.
- Double-buffered: the assembly buffer and the output buffer are separate, so filling continues while a finished vector waits.

Parameters:
- DIM_C, default `` `DIM_C `` (DEF.sv): lanes per weight vector.
- WEIGHT_WIDTH, default `` `WEIGHT_WIDTH `` (DEF.sv): bits per weight.
- CNT_W, default $clog2(DIM_C+1): lane-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  serial weight valid
- in_ready  out  1  loader can accept a weight
- in_data  in  WEIGHT_WIDTH  serial weight, lane 0 first
- in_last  in  1  final weight of a short vector; remaining lanes zero-filled
- out_valid  out  1  assembled vector available
- out_ready  in  1  consumer takes vector
- out  out  [DIM_C-1:0][WEIGHT_WIDTH-1:0]  assembled vector, registered
- out_partial  out  1  vector was closed by in_last before lane DIM_C-1

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, lane counter=0, assembly buffer=0.
  - out=0, out_valid=0, out_partial=0, in_ready=1.
- FSM states:
  - FILL: accept beats.
  - FULL: assembly buffer complete, but the output buffer is occupied and not draining.
- Accepted beat: in_valid & in_ready. It writes in_data to asm[cnt] and increments cnt.
- Assembly closes on an accepted beat when cnt==DIM_C-1 or in_last=1.
  - Lanes above the written lane read 0 in the transferred vector.
  - partial flag = in_last & (cnt!=DIM_C-1).
- Transfer to the output buffer happens on the closing beat if the output is free: out_valid=0, or out_valid & out_ready in the same cycle.
  - Next cycle: out=vector, out_valid=1, out_partial=flag.
  - cnt returns to 0 and asm clears to 0. State stays FILL.
  - Latency from the closing beat to out_valid is one cycle.
- If the output is not free on the closing beat: state goes to FULL and in_ready=0.
  - In FULL, transfer happens on the first cycle out_ready=1. Next cycle out holds the new vector and state returns to FILL.
  - in_ready is 1 again from that next cycle.
- Output handshake:
  - out_valid & out_ready retires the vector.
  - If no transfer happens in the same cycle, out_valid drops next cycle and out keeps its last value.
  - Back-to-back: a full vector every DIM_C cycles with out_ready tied 1, no bubbles.
- in_ready is combinational from state only: 1 in FILL, 0 in FULL. It never depends on in_valid.
- in_last on a beat with cnt==DIM_C-1 is a normal full vector: out_partial=0.
- in_last without in_valid is ignored.
- out must be stable while out_valid=1 and out_ready=0.
- Reset asserted mid-fill discards the partial vector and any pending output. No vector is emitted after reset release until DIM_C fresh beats or in_last arrive.
- Counter never exceeds DIM_C-1; a wrap is impossible by construction.

Optional Feature:
- Macro: WLOAD_VEC_CNT_EN.
- Defined:
  - Adds output vec_cnt [15:0], reset 0.
  - Increments on each out_valid & out_ready and wraps 0xFFFF to 0x0000.
  - Partial vectors are counted.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package weight_pkg:
  - typedef weight_t logic [WEIGHT_WIDTH-1:0];
  - typedef weight_vec_t weight_t [DIM_C-1:0];
  - typedef enum {FILL, FULL} wload_state_e;
  - lane-counter width constant.
- One sub-module is natural: weight_out_buf, the single-entry output holding register with valid/ready and the partial flag. weight_loader holds the FSM, counter and assembly buffer.

Test Plan:
- Bench config DIM_C=4, WEIGHT_WIDTH=8.
- Full vector: beats 0x11,0x22,0x33,0x44 with out_ready=1 -> one cycle after the 4th beat out={0x44,0x33,0x22,0x11} (lane3..0), out_valid=1, out_partial=0.
- Short vector: beats 0xA1,0xA2 with in_last on 0xA2 -> out={0x00,0x00,0xA2,0xA1}, out_partial=1; the next vector starts at lane 0.
- Backpressure: out_ready=0, send 8 beats -> first vector held stable; in_ready=0 after the 8th beat (state FULL). Raise out_ready -> the second vector appears the next cycle and in_ready returns to 1.
- Streaming: 12 contiguous beats, out_ready=1 -> 3 vectors at 4-cycle spacing, in_ready never deasserted.
- Reset mid-fill: 2 beats, pulse rst_n low asynchronously -> out=0, out_valid=0 immediately. Then 4 beats 0x01..0x04 -> out={0x04,0x03,0x02,0x01}.
- WLOAD_VEC_CNT_EN defined: 3 vectors retired -> vec_cnt=3. Preload 0xFFFF via force, retire 1 -> vec_cnt=0.
